// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, default widths and parity helper
package uart_pkg;

  localparam int UART_DEF_DATA_W     = 8;
  localparam int UART_DEF_OVERSAMPLE = 16;
  localparam int UART_DEF_FIFO_DEPTH = 16;
  localparam int UART_MAX_W          = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  // Parity bit a transmitter sends for the low nbits of data; ptype 0 = even, 1 = odd.
  function automatic logic calc_parity(input logic [UART_MAX_W-1:0] data,
                                       input logic [3:0]            nbits,
                                       input logic                  ptype);
    logic p;
    p = ptype;
    for (int i = 0; i < UART_MAX_W; i++) begin
      if (i < int'(nbits)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO; head output holds its last value when empty
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? hold : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (!empty)  hold   <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - oversampling UART receiver with majority vote, break detect
// and a receive FIFO drained through valid/ready.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DEF_DATA_W,
  parameter int OVERSAMPLE = UART_DEF_OVERSAMPLE,
  parameter int FIFO_DEPTH = UART_DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_tick,
  input  logic [1:0]                    i_num_bit_data,
  input  logic                          i_stop_bit,
  input  logic                          i_parity_en,
  input  logic                          i_parity_type,
  input  logic                          i_rx_serial,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_overrun,
  output logic                          o_break,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int ENT_W  = DATA_W + 2;
  localparam logic [TICK_W-1:0] S0_T   = TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_W-1:0] S1_T   = TICK_W'(OVERSAMPLE/2);
  localparam logic [TICK_W-1:0] VOTE_T = TICK_W'(OVERSAMPLE/2 + 1);
  localparam logic [TICK_W-1:0] END_T  = TICK_W'(OVERSAMPLE - 1);

  logic sync1, sync2, rx_prev, rx_s, fall;
  rx_state_t state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [CNT_W-1:0]  bit_cnt, bit_n, last_idx;
  logic              stop_idx, stop_idx_n;
  logic              s0, s0_n, s1, s1_n, vote;
  logic [DATA_W-1:0] data_r, data_n;
  logic              par_bit, par_bit_n, par_err, par_err_n, frm_err, frm_err_n;
  logic [1:0]        cfg_sel, cfg_sel_n;
  logic              cfg_stop2, cfg_stop2_n, cfg_par_en, cfg_par_en_n, cfg_par_odd, cfg_par_odd_n;
  logic              push_set, push_req, brk_set, brk_q, overrun_q;
  logic [ENT_W-1:0]  push_word, push_word_n, head;
  logic              in_frame, at_vote, bit_end;
  logic              fifo_full, fifo_empty, pop;

  assign rx_s     = sync2;
  assign fall     = rx_prev & ~rx_s;
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign in_frame = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign at_vote  = rx_tick && (tick_cnt == VOTE_T);
  assign bit_end  = rx_tick && (tick_cnt == END_T);
  assign last_idx = CNT_W'(DATA_W - 4) + CNT_W'(cfg_sel);

  always_comb begin
    state_n       = state;
    tick_n        = tick_cnt;
    bit_n         = bit_cnt;
    stop_idx_n    = stop_idx;
    s0_n          = s0;
    s1_n          = s1;
    data_n        = data_r;
    par_bit_n     = par_bit;
    par_err_n     = par_err;
    frm_err_n     = frm_err;
    cfg_sel_n     = cfg_sel;
    cfg_stop2_n   = cfg_stop2;
    cfg_par_en_n  = cfg_par_en;
    cfg_par_odd_n = cfg_par_odd;
    push_set      = 1'b0;
    push_word_n   = push_word;
    brk_set       = 1'b0;

    if (rx_tick && in_frame) begin
      tick_n = bit_end ? '0 : tick_cnt + 1'b1;
      if (tick_cnt == S0_T) s0_n = rx_s;
      if (tick_cnt == S1_T) s1_n = rx_s;
    end

    unique case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n       = ST_START;
          tick_n        = '0;
          bit_n         = '0;
          stop_idx_n    = 1'b0;
          data_n        = '0;
          par_bit_n     = 1'b0;
          par_err_n     = 1'b0;
          frm_err_n     = 1'b0;
          cfg_sel_n     = i_num_bit_data;
          cfg_stop2_n   = i_stop_bit;
          cfg_par_en_n  = i_parity_en;
          cfg_par_odd_n = i_parity_type;
        end
      end
      ST_START: begin
        if (at_vote && vote) state_n = ST_IDLE;
        else if (bit_end)    state_n = ST_DATA;
      end
      ST_DATA: begin
        if (at_vote) data_n[bit_cnt] = vote;
        if (bit_end) begin
          if (bit_cnt == last_idx) state_n = cfg_par_en ? ST_PARITY : ST_STOP;
          else                     bit_n   = bit_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (at_vote) begin
          par_bit_n = vote;
          par_err_n = calc_parity(UART_MAX_W'(data_r), 4'(last_idx) + 4'd1, cfg_par_odd) ^ vote;
        end
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (at_vote) begin
          if (!vote) frm_err_n = 1'b1;
          // An all-zero frame through the first stop bit is a break, not a byte.
          if (!stop_idx && !vote && (data_r == '0) && !(cfg_par_en && par_bit)) begin
            brk_set = 1'b1;
            state_n = ST_BRK_WAIT;
          end else if (stop_idx || !cfg_stop2) begin
            push_set    = 1'b1;
            push_word_n = {frm_err_n, par_err, data_r};
            state_n     = ST_IDLE;
          end
        end else if (bit_end) begin
          stop_idx_n = 1'b1;
        end
      end
      ST_BRK_WAIT: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      stop_idx    <= 1'b0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      data_r      <= '0;
      par_bit     <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      cfg_sel     <= '0;
      cfg_stop2   <= 1'b0;
      cfg_par_en  <= 1'b0;
      cfg_par_odd <= 1'b0;
      push_req    <= 1'b0;
      push_word   <= '0;
      brk_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1       <= i_rx_serial;
      sync2       <= sync1;
      rx_prev     <= sync2;
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      stop_idx    <= stop_idx_n;
      s0          <= s0_n;
      s1          <= s1_n;
      data_r      <= data_n;
      par_bit     <= par_bit_n;
      par_err     <= par_err_n;
      frm_err     <= frm_err_n;
      cfg_sel     <= cfg_sel_n;
      cfg_stop2   <= cfg_stop2_n;
      cfg_par_en  <= cfg_par_en_n;
      cfg_par_odd <= cfg_par_odd_n;
      push_req    <= push_set;
      push_word   <= push_word_n;
      brk_q       <= brk_set;
      overrun_q   <= push_req & fifo_full & ~pop;
    end
  end

  assign pop = ~fifo_empty & i_ready;

  uart_rx_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_fifo_level)
  );

  assign o_data       = head[DATA_W-1:0];
  assign o_parity_err = head[DATA_W];
  assign o_frame_err  = head[DATA_W+1];
  assign o_valid      = ~fifo_empty;
  assign o_overrun    = overrun_q;
  assign o_break      = brk_q;

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised successor to `uart_rx`: an oversampling UART receiver with configurable maximum data width and oversampling factor. It uses majority-vote bit sampling, framing-error and break detection, and a receive FIFO drained through a valid/ready interface. It sits between the baud-tick generator and the bus-side register block, and replaces direct use of `uart_rx` wherever software cannot service every byte immediately.

## Interface
- `DATA_W`, 8: maximum data bits; must be 5..9.
- `OVERSAMPLE`, 16: `rx_tick` pulses per bit; even, ≥8.
- `FIFO_DEPTH`, 16: entries; power of two, ≥2.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `rx_tick` in 1: one-cycle oversample enable.
- `i_num_bit_data` in 2: data bits = `DATA_W-3` + value (00→DATA_W-3 … 11→DATA_W).
- `i_stop_bit` in 1: 0 = one stop bit, 1 = two stop bits.
- `i_parity_en` in 1: parity bit present.
- `i_parity_type` in 1: 0 even, 1 odd.
- `i_rx_serial` in 1: asynchronous serial line, idle high.
- `o_data` out DATA_W: FIFO head data, right-justified, unused MSBs zero.
- `o_parity_err` out 1: head entry parity error flag.
- `o_frame_err` out 1: head entry framing error flag.
- `o_valid` out 1: FIFO non-empty.
- `i_ready` in 1: consumer pops head when `o_valid & i_ready`.
- `o_overrun` out 1: one-cycle pulse, frame dropped because FIFO full.
- `o_break` out 1: one-cycle pulse, break detected.
- `o_fifo_level` out $clog2(FIFO_DEPTH)+1: entries held.

## Operation
- `i_rx_serial` passes through a 2-flop synchronizer; both flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: synced falling edge → START, tick counter cleared. Frame config is latched here; config changes mid-frame are ignored.
- Each bit uses majority-of-3 sampling at ticks OVERSAMPLE/2-1, /2, /2+1. The bit ends on tick OVERSAMPLE-1.
- START: voted 1 → false start, return to IDLE with no push. Voted 0 → DATA.
- DATA: LSB first, N bits; then PARITY if enabled, else STOP.
- PARITY: `parity_err` = XOR(data bits, received parity, `i_parity_type`).
- STOP: each stop bit is evaluated at its vote. Any voted 0 sets `frame_err`. The second stop bit is checked only when `i_stop_bit`=1.
- Break: all data bits, parity (if enabled) and first stop bit voted 0 → `o_break` pulse, no push, go to BRK_WAIT. BRK_WAIT holds until the synced line is 1, then returns to IDLE.
- Push happens at the final stop-bit vote, not at the bit end, so an immediately following start edge is caught. The state returns to IDLE on that same tick.
- FIFO entry = {frame_err, parity_err, data}.
- Full at push time, no pop that cycle: entry dropped, `o_overrun` pulses, FIFO unchanged.
- Full with a simultaneous pop: push accepted, level stays FIFO_DEPTH.
- Empty with `i_ready`=1: no effect.

## Timing
- Reset values: all outputs 0; FIFO empty; state IDLE.
- Reset asserted mid-frame: frame discarded, FIFO flushed.
- Input edge to synced edge: 2 clk.
- Final stop-vote tick to `o_valid`=1: 2 clk. `o_data` and flags are valid in the same cycle as `o_valid`.
- Pop: head advances the cycle after `o_valid & i_ready`. A new head (if any) is presented on that edge.
- `o_fifo_level` updates the cycle after the push or pop.
- `o_overrun` and `o_break` are registered and asserted for exactly 1 clk.
- Outputs are undefined-free when `o_valid`=0: head data/flags hold their last value.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t`
  - default OVERSAMPLE and width localparams
  - function `calc_parity(data, nbits, type)`, shared with the TX side and the bench
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO.
  - width DATA_W+2, depth FIFO_DEPTH
  - ports push/pop/full/empty/level
  - asynchronous active-low reset

## Test plan
- 8N1 `0xA5`, `i_ready`=1 → one `o_valid` beat, `o_data`=0xA5, both error flags 0, level returns to 0.
- 5-bit odd parity, 2 stop bits, `0x15` → `o_data`=0x15 (upper bits 0), `o_parity_err`=0.
- 8-bit even parity `0x3C` with inverted parity bit → entry `0x3C` with `o_parity_err`=1; a following clean `0x3C` has the flag 0.
- 8N1 `0x55` with stop bit driven 0 → `o_frame_err`=1. Line held low 12 bit-times → one `o_break` pulse, no push, then a clean `0xA5` is received.
- `i_ready`=0, FIFO_DEPTH+1 frames `0x00..0x10` → level=16 and one `o_overrun` pulse. Drain yields `0x00..0x0F` in order.
- Line low for 4 ticks only → no push. `rst_n` asserted mid-frame → level 0 and outputs 0; the next frame `0x81` is received correctly.
